// File: rtl/inv_mixcol_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : inv_mixcol_seq_if
// Description : Handshake bundle for inv_mixcol_seq. Carries the input state
//               stream (in_valid/in_ready/in_data/in_bypass) and the output
//               state stream (out_valid/out_ready/out_data).
//               master : the side that supplies states and consumes results
//               slave  : the inverse-MixColumns block
// Revision    : 1.0 - initial release
// ============================================================================
interface inv_mixcol_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_bypass, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_bypass, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/inv_mixcol_seq.sv
`default_nettype none
// ============================================================================
// Module      : inv_mixcol_seq
// Description : Sequential AES InvMixColumns. One 32-bit column transform is
//               time-shared over the four columns of a 128-bit state, one
//               column per clock. A bypass input passes the state through
//               unchanged (final decrypt round).
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - inv_mixcol_seq_if.slave (input/output handshakes)
//               busy - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module inv_mixcol_seq (
  input  logic                 clk,
  input  logic                 rst,
  inv_mixcol_seq_if.slave      bus,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_col;
  // Packed as [column index][32 bits]; column c lives at index 3-c so that
  // column 0 occupies bits [127:96].
  logic [3:0][31:0]   r_src;
  logic [3:0][31:0]   r_res;
  logic [1:0]         w_idx;
  logic [31:0]        w_col_in;
  logic [31:0]        w_col_out;

  // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {0E*b, 0B*b, 0D*b, 09*b}
  function automatic logic [31:0] mults(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    mults = {x8 ^ x4 ^ x2, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ b};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [31:0] m0, m1, m2, m3;
    m0 = mults(a[31:24]);
    m1 = mults(a[23:16]);
    m2 = mults(a[15:8]);
    m3 = mults(a[7:0]);
    // Byte order in each m: [31:24]=0E [23:16]=0B [15:8]=0D [7:0]=09
    inv_mix_col[31:24] = m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0];
    inv_mix_col[23:16] = m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8];
    inv_mix_col[15:8]  = m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16];
    inv_mix_col[7:0]   = m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24];
  endfunction

  // The single shared column transform
  assign w_idx     = 2'd3 - r_col;
  assign w_col_in  = r_src[w_idx];
  assign w_col_out = inv_mix_col(w_col_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= 2'd0;
      r_src   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_src <= bus.in_data;
            r_col <= 2'd0;
            if (bus.in_bypass) begin
              r_res <= bus.in_data;
            end
          end
        end
        S_BUSY: begin
          r_res[w_idx] <= w_col_out;
          r_col        <= r_col + 2'd1;   // wraps to 0 after column 3
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.in_valid)   w_next = bus.in_bypass ? S_DONE : S_BUSY;
      S_BUSY: if (r_col == 2'd3)  w_next = S_DONE;
      S_DONE: if (bus.out_ready)  w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_data  = r_res;
  assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_inv_mixcol_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_mixcol_seq
// Description : Self-checking bench for inv_mixcol_seq: known-answer, bypass,
//               backpressure, reset mid-operation, back-to-back and random
//               transactions against a matrix-form GF(2^8) reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_mixcol_seq;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_prev = 0;
  int   acc_last = 0;

  inv_mixcol_seq_if bus_if ();

  inv_mixcol_seq dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_if.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: textbook GF(2^8) shift-and-add multiply and the
  // circulant inverse matrix applied column by column.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   r;
    logic [127:0] o;
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r = r ^ gf_mul(m[(j - i + 4) % 4], a[j]);
        o[127 - 32*c - 8*i -: 8] = r;
      end
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction starting at a falling edge with the DUT idle and
  // ends at a falling edge with the DUT idle again. During the operation
  // in_valid may stay high with junk data, which must be ignored.
  task automatic run_txn(input logic [127:0] data, input logic byp,
                         input logic [127:0] exp, input int stall,
                         input logic keep_valid);
    logic [127:0] held;
    int  k;
    bit  seen;
    check("in_ready_idle", {127'b0, bus_if.in_ready}, 128'd1);
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = data;
    bus_if.in_bypass = byp;
    bus_if.out_ready = 1'($urandom);
    acc_prev = acc_last;
    acc_last = cyc;
    seen = 0;
    k    = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (bus_if.out_valid) begin
        seen = 1;
      end else begin
        check("busy_wait", {127'b0, busy}, 128'd1);
        check("in_ready_wait", {127'b0, bus_if.in_ready}, 128'd0);
      end
      bus_if.in_valid  = keep_valid;
      bus_if.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus_if.in_bypass = 1'($urandom);
      bus_if.out_ready = seen ? (stall == 0) : 1'($urandom);
    end
    check("latency", 128'(k), byp ? 128'd1 : 128'd5);
    if (seen) begin
      check("out_data", bus_if.out_data, exp);
      held = bus_if.out_data;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_valid", {127'b0, bus_if.out_valid}, 128'd1);
        check("stall_data", bus_if.out_data, held);
        check("stall_busy", {127'b0, busy}, 128'd1);
        check("stall_in_ready", {127'b0, bus_if.in_ready}, 128'd0);
        bus_if.in_data   = {$urandom, $urandom, $urandom, $urandom};
        bus_if.out_ready = (s == stall - 1);
      end
      @(negedge clk);
      check("post_hs_valid", {127'b0, bus_if.out_valid}, 128'd0);
      check("post_hs_in_ready", {127'b0, bus_if.in_ready}, 128'd1);
      check("post_hs_busy", {127'b0, busy}, 128'd0);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
  endtask

  logic [127:0] kat_in, kat_out, byp_in, d;
  logic         b;

  initial begin
    kat_in  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    kat_out = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    byp_in  = 128'h00112233_44556677_8899aabb_ccddeeff;
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.in_bypass = 1'b0;
    bus_if.out_ready = 1'b0;
    #1;
    check("rst_out_valid", {127'b0, bus_if.out_valid}, 128'd0);
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_out_data", bus_if.out_data, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Known answer, then bypass, then backpressure with junk in_valid
    run_txn(kat_in, 1'b0, kat_out, 0, 1'b0);
    run_txn(byp_in, 1'b1, byp_in, 0, 1'b0);
    run_txn(kat_in, 1'b0, kat_out, 10, 1'b1);

    // Back-to-back: in_valid held high, accepts six cycles apart
    run_txn(byp_in, 1'b0, ref_inv(byp_in), 0, 1'b1);
    run_txn(kat_in, 1'b0, kat_out, 0, 1'b1);
    check("b2b_spacing", 128'(acc_last - acc_prev), 128'd6);

    // Reset while BUSY with col=2
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = kat_in;
    bus_if.in_bypass = 1'b0;
    repeat (3) @(negedge clk);
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {127'b0, bus_if.out_valid}, 128'd0);
    check("midrst_out_data", bus_if.out_data, 128'd0);
    check("midrst_busy", {127'b0, busy}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("postrst_out_valid", {127'b0, bus_if.out_valid}, 128'd0);
      check("postrst_in_ready", {127'b0, bus_if.in_ready}, 128'd1);
    end

    // Reset while DONE (bypass result held by backpressure)
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = byp_in;
    bus_if.in_bypass = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check("done_before_rst", {127'b0, bus_if.out_valid}, 128'd1);
    rst = 1'b1;
    #1;
    check("donerst_out_valid", {127'b0, bus_if.out_valid}, 128'd0);
    check("donerst_out_data", bus_if.out_data, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst2_out_valid", {127'b0, bus_if.out_valid}, 128'd0);
    end

    // Random transactions
    for (int n = 0; n < 1000; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      b = ($urandom_range(0, 3) == 0);
      run_txn(d, b, b ? d : ref_inv(d),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
              1'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inv_mixcol_seq.md
INV_MIXCOL_SEQ -- requirements
Module: inv_mixcol_seq

Interface
REQ-001 Parameters: none. All widths are fixed: 128-bit state, 32-bit column.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst  input  1  Asynchronous, active-high reset.
REQ-004 in_valid  input  1  in_data / in_bypass valid.
REQ-005 in_ready  output  1  Block can accept a state.
REQ-006 in_data  input  128  AES state, column-major. Column c is bits [127-32c : 96-32c]. Row 0 of each column is the MS byte.
REQ-007 in_bypass  input  1  When 1, pass in_data through unchanged; used for the final decrypt round.
REQ-008 out_valid  output  1  out_data valid.
REQ-009 out_ready  input  1  Downstream accepts out_data.
REQ-010 out_data  output  128  Result state, same column layout as in_data.
REQ-011 busy  output  1  High whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL contain exactly one 32-bit inverse-MixColumns combinational instance, time-shared across the four columns.
REQ-013 Per column, the instance SHALL compute:
- r0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
- r1 = 09·a0 ^ 0E·a1 ^ 0B·a2 ^ 0D·a3
- r2 = 0D·a0 ^ 09·a1 ^ 0E·a2 ^ 0B·a3
- r3 = 0B·a0 ^ 0D·a1 ^ 09·a2 ^ 0E·a3

Here a0 is the MS byte, and multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1.
REQ-014 FSM states SHALL be IDLE, BUSY and DONE.
REQ-015 in_ready SHALL equal 1 only in IDLE; it is combinational from state only.
REQ-016 Accept: in IDLE with in_valid=1, the block SHALL register in_data into the source register src and clear the 2-bit column counter col to 0.
- If in_bypass=0: next state BUSY.
- If in_bypass=1: copy in_data into the result register res; next state DONE.
REQ-017 BUSY: each cycle the block SHALL drive src column col into the shared instance and write the result into res column col, then increment col.
REQ-018 BUSY SHALL exit to DONE on the cycle that processes col=3; col then wraps to 0.
REQ-019 Latency:
- Non-bypass: out_valid SHALL rise exactly 5 cycles after the accept edge (1 load + 4 columns).
- Bypass: out_valid SHALL rise 1 cycle after the accept edge.
REQ-020 DONE: out_valid=1 and out_data=res, both held stable until out_ready=1.
- out_ready=1 in DONE: next state IDLE.
- out_valid SHALL deassert on the following cycle.
REQ-021 out_ready SHALL be ignored outside DONE. in_valid SHALL be ignored outside IDLE, with no capture and no state change.
REQ-022 No back-to-back overlap: the earliest next accept SHALL be the cycle after the DONE handshake. Maximum throughput is one state per 6 cycles (non-bypass) or per 2 cycles (bypass).
REQ-023 out_valid SHALL depend only on state; out_data SHALL come only from the res register, with no combinational path from in_data.
REQ-024 res columns not yet written during BUSY SHALL hold their previous values. They are not observable, because out_valid=0.

Reset
REQ-025 On rst=1, asynchronously and regardless of state:
- FSM goes to IDLE.
- col, src and res are cleared to 0.
- out_valid=0, busy=0, out_data=128'h0; in_ready=1 after reset is released.
REQ-026 Reset asserted mid-BUSY or mid-DONE SHALL discard the in-flight state; no out_valid pulse SHALL follow reset release.
REQ-027 The first accept SHALL be possible on the first rising edge with rst=0.

Verification
REQ-028 Non-bypass known-answer test: in_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_bypass=0, out_ready=1.
- out_data = db135345_f20a225c_01010101_c6c6c6c6.
- out_valid is high exactly on cycle +5, for 1 cycle.
REQ-029 Bypass: in_data = 00112233_44556677_8899aabb_ccddeeff, in_bypass=1.
- out_data equals in_data at cycle +1.
- The shared instance output is not used.
REQ-030 Backpressure: load the REQ-028 vector and hold out_ready=0 for 10 cycles.
- out_valid and out_data stay stable throughout.
- in_ready=0 and busy=1 throughout.
- A second in_valid pulse during the stall is ignored.
- On out_ready=1 the handshake completes, and IDLE is reached the next cycle.
REQ-031 Reset mid-operation: assert rst when col=2 in BUSY.
- Immediately: out_valid=0, out_data=0, busy=0.
- After release: in_ready=1, and no spurious out_valid occurs.
REQ-032 Back-to-back: present two vectors with in_valid held high and out_ready=1.
- The second accept occurs the cycle after the first DONE handshake.
- Both results are correct and arrive in order.
- There are 6 cycles between accepts.
REQ-033 Random test: 1000 random states with random bypass and out_ready.
- Compare against a software InvMixColumns model.
- Check the REQ-019 latency and REQ-020 stability on every transaction.
